grey_decade_counter: RTL and testbench

- 12-digit synchronous decimal counter; each digit is a 5-bit Johnson (twisted-ring) code, so exactly one bit changes per digit step.
- Digits run ones through hundred-billions and are loadable from a 60-bit init word while in reset.
- An 8-bit display port shows one digit, chosen by a select input, as seven-segment or raw code.
- It is the core of the chip top level, which drives i_clk, i_rst and i_sel and exposes only o_cnt.

---
 rtl/grey_decade_counter.sv | 138 +++++++++++++
 tb/tb_grey_decade_counter.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grey_decade_counter.sv
`default_nettype none
// ============================================================================
//  Module      : grey_decade_counter
//  Description : Twelve-digit synchronous decimal counter with 5-bit Johnson
//                coded digits, a parallel reset-load and a one-digit display
//                byte (seven-segment or raw code plus terminal-count flag).
//  Revision    : 1.0 - initial release
// ============================================================================
module grey_decade_counter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [7:0]  i_sel,
    input  logic [59:0] init,
    output logic [4:0]  ones,
    output logic [4:0]  tens,
    output logic [4:0]  hund,
    output logic [4:0]  thou,
    output logic [4:0]  tenT,
    output logic [4:0]  hunT,
    output logic [4:0]  mil,
    output logic [4:0]  tenM,
    output logic [4:0]  hunM,
    output logic [4:0]  bil,
    output logic [4:0]  tenB,
    output logic [4:0]  hunB,
    output logic [7:0]  o_cnt
);

    localparam int         c_DIGITS = 12;
    localparam logic [4:0] c_NINE   = 5'b10000;

    // True for the ten codes of the Johnson loop; anything else is sanitised.
    function automatic logic is_valid(input logic [4:0] code);
        case (code)
            5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
            5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000: is_valid = 1'b1;
            default:                                          is_valid = 1'b0;
        endcase
    endfunction

    // Johnson code to active-high gfedcba segments.
    function automatic logic [6:0] seg_of(input logic [4:0] code);
        case (code)
            5'b00000: seg_of = 7'h3F;
            5'b00001: seg_of = 7'h06;
            5'b00011: seg_of = 7'h5B;
            5'b00111: seg_of = 7'h4F;
            5'b01111: seg_of = 7'h66;
            5'b11111: seg_of = 7'h6D;
            5'b11110: seg_of = 7'h7D;
            5'b11100: seg_of = 7'h07;
            5'b11000: seg_of = 7'h7F;
            5'b10000: seg_of = 7'h6F;
            default:  seg_of = 7'h00;
        endcase
    endfunction

    logic [c_DIGITS-1:0][4:0] digit_q;
    logic [c_DIGITS-1:0][4:0] digit_d;
    logic [c_DIGITS-1:0][4:0] load_d;
    logic [c_DIGITS-1:0]      is_nine;
    // carry[k] is high when every digit below k currently holds nine.
    logic [c_DIGITS:0]        carry;

    assign carry[0] = 1'b1;

    generate
        for (genvar k = 0; k < c_DIGITS; k++) begin : g_carry
            assign is_nine[k]   = (digit_q[k] == c_NINE);
            assign carry[k+1]   = carry[k] & is_nine[k];
        end
    endgenerate

    // Sanitised reset-load value and counting next state for every digit.
    always_comb begin
        load_d  = '0;
        digit_d = digit_q;
        for (int k = 0; k < c_DIGITS; k++) begin
            load_d[k] = is_valid(init[5*k +: 5]) ? init[5*k +: 5] : 5'b00000;
            if (carry[k]) begin
                digit_d[k] = {digit_q[k][3:0], ~digit_q[k][4]};
            end
        end
    end

    // Digit registers: reset-load takes priority over counting.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            digit_q <= load_d;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign ones = digit_q[0];
    assign tens = digit_q[1];
    assign hund = digit_q[2];
    assign thou = digit_q[3];
    assign tenT = digit_q[4];
    assign hunT = digit_q[5];
    assign mil  = digit_q[6];
    assign tenM = digit_q[7];
    assign hunM = digit_q[8];
    assign bil  = digit_q[9];
    assign tenB = digit_q[10];
    assign hunB = digit_q[11];

    logic [4:0] sel_code;
    logic       sel_hit;
    logic [6:0] disp_low;
    logic       sel_unused;

    // Upper select bits carry no meaning for this block.
    assign sel_unused = ^i_sel[7:5];

    // Display mux: indices 12..15 select nothing and blank the low bits.
    always_comb begin
        sel_code = 5'b00000;
        sel_hit  = 1'b0;
        for (int k = 0; k < c_DIGITS; k++) begin
            if (i_sel[3:0] == k[3:0]) begin
                sel_code = digit_q[k];
                sel_hit  = 1'b1;
            end
        end
        if (!sel_hit) begin
            disp_low = 7'h00;
        end else if (i_sel[4]) begin
            disp_low = {2'b00, sel_code};
        end else begin
            disp_low = seg_of(sel_code);
        end
    end

    assign o_cnt = {carry[c_DIGITS], disp_low};

endmodule
`default_nettype wire

// File: tb/tb_grey_decade_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_grey_decade_counter
//  Description : Self-checking bench for grey_decade_counter. A decimal model
//                predicts digits and display byte; expectations are queued when
//                stimulus is applied and popped when the DUT output is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_grey_decade_counter;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [7:0]  i_sel = 8'h00;
    logic [59:0] init  = '0;
    logic [4:0]  ones, tens, hund, thou, tenT, hunT;
    logic [4:0]  mil, tenM, hunM, bil, tenB, hunB;
    logic [7:0]  o_cnt;

    wire [59:0] dig_w = {hunB, tenB, bil, hunM, tenM, mil,
                         hunT, tenT, thou, hund, tens, ones};

    int checks = 0;
    int errors = 0;

    int vals [12];
    logic [59:0] exp_dig_q [$];
    logic [7:0]  exp_cnt_q [$];

    localparam logic [4:0] JC  [10] = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111,
                                        5'b11111, 5'b11110, 5'b11100, 5'b11000, 5'b10000};
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    grey_decade_counter dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_sel (i_sel),
        .init  (init),
        .ones  (ones),
        .tens  (tens),
        .hund  (hund),
        .thou  (thou),
        .tenT  (tenT),
        .hunT  (hunT),
        .mil   (mil),
        .tenM  (tenM),
        .hunM  (hunM),
        .bil   (bil),
        .tenB  (tenB),
        .hunB  (hunB),
        .o_cnt (o_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Model: Johnson word for the current decimal values.
    function automatic logic [59:0] model_word();
        logic [59:0] w;
        w = '0;
        for (int k = 0; k < 12; k++) w[5*k +: 5] = JC[vals[k]];
        return w;
    endfunction

    // Model: expected display byte for a given select.
    function automatic logic [7:0] model_cnt(input logic [7:0] sel);
        logic       term;
        logic [6:0] low;
        int         idx;
        term = 1'b1;
        for (int k = 0; k < 12; k++) if (vals[k] != 9) term = 1'b0;
        idx = int'(sel[3:0]);
        if (idx > 11)    low = 7'h00;
        else if (sel[4]) low = {2'b00, JC[vals[idx]]};
        else             low = SEG[vals[idx]];
        return {term, low};
    endfunction

    // Model: decimal increment with wrap.
    function automatic void model_inc();
        for (int k = 0; k < 12; k++) begin
            vals[k] = vals[k] + 1;
            if (vals[k] < 10) return;
            vals[k] = 0;
        end
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [59:0] d;
        logic [7:0]  c;
        for (int k = 0; k < 12; k++) vals[k] = 0;
        init  = model_word();
        i_rst = 1'b0;
        i_sel = 8'h00;
        exp_dig_q.push_back(60'h0);
        exp_cnt_q.push_back(8'h3F);
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL reset_digits: got %h expected %h", dig_w, d);
        end
        c = exp_cnt_q.pop_front();
        checks++;
        if (o_cnt !== c) begin
            errors++;
            $display("FAIL reset_ocnt: got %h expected %h", o_cnt, c);
        end
    endtask

    task automatic test_count();
        logic [59:0] d;
        logic [7:0]  c;
        i_rst = 1'b1;
        i_sel = 8'h00;
        for (int i = 0; i < 10; i++) begin
            model_inc();
            exp_dig_q.push_back(model_word());
            exp_cnt_q.push_back(model_cnt(i_sel));
            tick();
            d = exp_dig_q.pop_front();
            checks++;
            if (dig_w !== d) begin
                errors++;
                $display("FAIL count_digits[%0d]: got %h expected %h", i, dig_w, d);
            end
            c = exp_cnt_q.pop_front();
            checks++;
            if (o_cnt !== c) begin
                errors++;
                $display("FAIL count_ocnt[%0d]: got %h expected %h", i, o_cnt, c);
            end
        end
        checks++;
        if (ones !== 5'b00000 || tens !== 5'b00001) begin
            errors++;
            $display("FAIL count_tens: got tens=%b ones=%b expected tens=00001 ones=00000", tens, ones);
        end
    endtask

    task automatic test_carry();
        logic [59:0] d;
        for (int k = 0; k < 12; k++) vals[k] = (k < 9) ? 9 : 0;
        init  = model_word();
        i_rst = 1'b0;
        exp_dig_q.push_back(model_word());
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL carry_load: got %h expected %h", dig_w, d);
        end
        i_rst = 1'b1;
        model_inc();
        exp_dig_q.push_back(model_word());
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL carry_step: got %h expected %h", dig_w, d);
        end
    endtask

    task automatic test_wrap();
        logic [59:0] d;
        logic [7:0]  c;
        for (int k = 0; k < 12; k++) vals[k] = 9;
        init  = model_word();
        i_rst = 1'b0;
        exp_dig_q.push_back(model_word());
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL wrap_load: got %h expected %h", dig_w, d);
        end
        i_sel = 8'h05;
        exp_cnt_q.push_back(8'hEF);
        #1;
        c = exp_cnt_q.pop_front();
        checks++;
        if (o_cnt !== c) begin
            errors++;
            $display("FAIL wrap_terminal: got %h expected %h", o_cnt, c);
        end
        i_rst = 1'b1;
        model_inc();
        exp_dig_q.push_back(model_word());
        exp_cnt_q.push_back(8'h3F);
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL wrap_step: got %h expected %h", dig_w, d);
        end
        c = exp_cnt_q.pop_front();
        checks++;
        if (o_cnt !== c) begin
            errors++;
            $display("FAIL wrap_ocnt: got %h expected %h", o_cnt, c);
        end
    endtask

    task automatic test_display();
        logic [59:0] d;
        logic [7:0]  c;
        logic [7:0]  sels [8] = '{8'h03, 8'h13, 8'h0C, 8'h1F, 8'h63, 8'hF3, 8'hEC, 8'hBF};
        logic [7:0]  exps [8] = '{8'h07, 8'h1C, 8'h00, 8'h00, 8'h07, 8'h1C, 8'h00, 8'h00};
        for (int k = 0; k < 12; k++) vals[k] = 0;
        vals[3] = 7;
        init  = model_word();
        i_rst = 1'b0;
        exp_dig_q.push_back(model_word());
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL display_load: got %h expected %h", dig_w, d);
        end
        for (int i = 0; i < 8; i++) begin
            i_sel = sels[i];
            exp_cnt_q.push_back(exps[i]);
            #1;
            c = exp_cnt_q.pop_front();
            checks++;
            if (o_cnt !== c) begin
                errors++;
                $display("FAIL display_sel_%h: got %h expected %h", sels[i], o_cnt, c);
            end
        end
    endtask

    task automatic test_random_display();
        logic [59:0] d;
        logic [7:0]  c;
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 12; k++) vals[k] = int'($urandom_range(0, 9));
            init  = model_word();
            i_rst = 1'b0;
            exp_dig_q.push_back(model_word());
            tick();
            d = exp_dig_q.pop_front();
            checks++;
            if (dig_w !== d) begin
                errors++;
                $display("FAIL rand_load[%0d]: got %h expected %h", r, dig_w, d);
            end
            for (int s = 0; s < 32; s++) begin
                i_sel = {3'($urandom_range(0, 7)), 5'(s)};
                exp_cnt_q.push_back(model_cnt(i_sel));
                #1;
                c = exp_cnt_q.pop_front();
                checks++;
                if (o_cnt !== c) begin
                    errors++;
                    $display("FAIL rand_sel_%h: got %h expected %h", i_sel, o_cnt, c);
                end
            end
        end
    endtask

    task automatic test_invalid_midreset();
        logic [59:0] d;
        int          saved [12];
        for (int k = 0; k < 12; k++) vals[k] = 0;
        vals[1]  = 3;
        vals[11] = 5;
        init       = model_word();
        init[4:0]  = 5'b10101;
        i_rst      = 1'b0;
        i_sel      = 8'h10;
        saved      = vals;
        exp_dig_q.push_back(model_word());
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL invalid_load: got %h expected %h", dig_w, d);
        end
        i_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            model_inc();
            exp_dig_q.push_back(model_word());
            tick();
            d = exp_dig_q.pop_front();
            checks++;
            if (dig_w !== d) begin
                errors++;
                $display("FAIL midreset_count[%0d]: got %h expected %h", i, dig_w, d);
            end
        end
        i_rst = 1'b0;
        vals  = saved;
        exp_dig_q.push_back(model_word());
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL midreset_reload: got %h expected %h", dig_w, d);
        end
        i_rst = 1'b1;
        model_inc();
        exp_dig_q.push_back(model_word());
        tick();
        d = exp_dig_q.pop_front();
        checks++;
        if (dig_w !== d) begin
            errors++;
            $display("FAIL midreset_resume: got %h expected %h", dig_w, d);
        end
    endtask

    task automatic test_back_to_back();
        logic [59:0] d;
        logic [7:0]  c;
        for (int k = 0; k < 12; k++) vals[k] = (k < 6) ? 9 : int'($urandom_range(0, 9));
        vals[0] = 2;
        init  = model_word();
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        for (int i = 0; i < 150; i++) begin
            i_sel = 8'(i % 13);
            model_inc();
            exp_dig_q.push_back(model_word());
            exp_cnt_q.push_back(model_cnt(i_sel));
            tick();
            d = exp_dig_q.pop_front();
            checks++;
            if (dig_w !== d) begin
                errors++;
                $display("FAIL b2b_digits[%0d]: got %h expected %h", i, dig_w, d);
            end
            c = exp_cnt_q.pop_front();
            checks++;
            if (o_cnt !== c) begin
                errors++;
                $display("FAIL b2b_ocnt[%0d]: got %h expected %h", i, o_cnt, c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count();
        test_carry();
        test_wrap();
        test_display();
        test_random_display();
        test_invalid_midreset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
